// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared state type, access size codes and size helper for ram_sync_byte
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } ram_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  // A zero count marks the reserved size code.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      SIZE_WORD: size_bytes = 3'd4;
      default:   size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ram_load_align.sv
// rtl/ram_load_align.sv - assembles little-endian read bytes into a 32-bit load result
// with zero or sign extension of byte and halfword loads.
module ram_load_align
  import ram_pkg::*;
(
  input  logic [31:0] raw_bytes,
  input  logic [1:0]  size,
  input  logic        signed_load,
  output logic [31:0] load_data
);

  always_comb begin
    load_data = raw_bytes;
    case (size)
      SIZE_BYTE: load_data = {{24{signed_load & raw_bytes[7]}}, raw_bytes[7:0]};
      SIZE_HALF: load_data = {{16{signed_load & raw_bytes[15]}}, raw_bytes[15:0]};
      default:   load_data = raw_bytes;
    endcase
  end

endmodule

// File: rtl/ram_sync_byte.sv
// rtl/ram_sync_byte.sv - byte-addressable RAM with request/complete handshake and wait states.
// Optional RAM_ALIGN_CHECK_EN rejects misaligned halfword and word accesses.
module ram_sync_byte
  import ram_pkg::*;
#(
  parameter int DEPTH       = 512,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int WAIT_STATES = 0
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  memFuncActive,
  input  logic                  readWrite,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           dataIn,
  input  logic [1:0]            dataSize,
  input  logic                  signedLoad,
  output logic [31:0]           dataOut,
  output logic                  memFuncComplete,
  output logic                  memError
);

  ram_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            size_q, size_d;
  logic                  sgn_q, sgn_d;
  logic [31:0]           dout_q, dout_d;
  logic                  cmpl_q, cmpl_d;
  logic                  err_q, err_d;

  logic [7:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] byte_addr [4];
  logic [31:0]           raw_bytes;
  logic [31:0]           load_data;
  logic [3:0]            byte_en;
  logic                  misaligned;
  logic                  reject;

  // Byte lanes wrap modulo DEPTH through the natural overflow of the address width.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      byte_addr[k] = addr_q + ADDR_WIDTH'(k);
    end
  end

  assign raw_bytes = {mem[byte_addr[3]], mem[byte_addr[2]], mem[byte_addr[1]], mem[byte_addr[0]]};

`ifdef RAM_ALIGN_CHECK_EN
  assign misaligned = ((size_q == SIZE_HALF) && addr_q[0]) ||
                      ((size_q == SIZE_WORD) && (addr_q[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign reject = (size_bytes(size_q) == 3'd0) || misaligned;

  ram_load_align u_load_align (
    .raw_bytes   (raw_bytes),
    .size        (size_q),
    .signed_load (sgn_q),
    .load_data   (load_data)
  );

  always_comb begin
    byte_en = 4'b0000;
    if ((state_q == ACCESS) && rw_q && !reject) begin
      for (int k = 0; k < 4; k++) begin
        byte_en[k] = (3'(k) < size_bytes(size_q));
      end
    end
  end

  // Memory contents are deliberately left out of reset.
  always_ff @(posedge Clk) begin
    for (int k = 0; k < 4; k++) begin
      if (byte_en[k]) begin
        mem[byte_addr[k]] <= wdata_q[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    dout_d  = dout_q;
    cmpl_d  = cmpl_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (memFuncActive) begin
          rw_d    = readWrite;
          addr_d  = address;
          wdata_d = dataIn;
          size_d  = dataSize;
          sgn_d   = signedLoad;
          if (WAIT_STATES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cmpl_d  = 1'b1;
        err_d   = reject;
        state_d = DONE;
        if (!rw_q && !reject) begin
          dout_d = load_data;
        end
      end
      DONE: begin
        if (!memFuncActive) begin
          cmpl_d  = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      size_q  <= SIZE_BYTE;
      sgn_q   <= 1'b0;
      dout_q  <= 32'd0;
      cmpl_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      dout_q  <= dout_d;
      cmpl_q  <= cmpl_d;
      err_q   <= err_d;
    end
  end

  assign dataOut         = dout_q;
  assign memFuncComplete = cmpl_q;
  assign memError        = err_q;

endmodule
